// File: rtl/i2s_define.sv
// Shared I2S definitions: channel-length codes, the channel-length to bit-count
// lookup, and the transmit serializer state encoding and control register layout.
package i2s_define;

  localparam int unsigned CntW = 6;

  // Channel length codes as driven on chl_i.
  typedef enum logic [1:0] {
    Chl8  = 2'd0,
    Chl16 = 2'd1,
    Chl24 = 2'd2,
    Chl32 = 2'd3
  } chl_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSync = 2'd1,
    StRun  = 2'd2
  } tx_state_e;

  // All narrow transmitter state, held in a single register cell.
  typedef struct packed {
    tx_state_e       state;
    logic            buf_vld;
    logic [CntW-1:0] cnt;
    logic            ws_last;
    logic            sd;
    logic            underrun;
    logic [CntW-1:0] n;
    logic            pol;
  } tx_ctrl_t;

  // Bits per sample for a channel length code: 8 * (code + 1).
  function automatic logic [CntW-1:0] chl_bits(chl_e chl);
    return {1'b0, chl, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/i2s_txser_reg.sv
// Sync-reset register cell used for every flop of the I2S transmit serializer.
// Ports: clk_i clock, rst_i synchronous active-high reset (clears to zero),
//        d_i next value, q_o registered value.
module i2s_txser_reg #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= '0;
    end else begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/i2s_txser.sv
// I2S transmit serializer. Takes LSB-aligned samples through a one-entry
// holding buffer and shifts them out MSB-first on sd_o, one bit per SCK
// return-to-idle edge, with the standard one-SCK delay after a WS change.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   en_i                    enable; low returns to idle next cycle
//   pol_i, chl_i            SCK idle level and channel length code (sampled in idle)
//   sck_i, sck_trg_i, ws_i  clock generator view (SCK level, toggle pulse, word select)
//   tx_data_i, tx_valid_i   sample input; tx_ready_o accepts
//   sd_o                    serial data
//   underrun_o              one-cycle pulse when a channel starts with no sample
//   busy_o                  high while transmitting (RUN)
module i2s_txser
  import i2s_define::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              pol_i,
  input  logic [1:0]        chl_i,
  input  logic              sck_i,
  input  logic              sck_trg_i,
  input  logic              ws_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic              sd_o,
  output logic              underrun_o,
  output logic              busy_o
);

  tx_ctrl_t          ctrl_q, ctrl_d;
  logic [DATA_W-1:0] buf_word_q, buf_word_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              buf_vld_q, ws_last_q;
  logic              se, wsc, hs;
  logic [31:0]       n_ext, shamt;

  assign buf_vld_q = ctrl_q.buf_vld;
  assign ws_last_q = ctrl_q.ws_last;

  // Shift event: SCK is about to return to its idle level.
  assign se  = sck_trg_i && (sck_i != ctrl_q.pol);
  // Channel start: WS differs from the value seen at the previous shift event.
  assign wsc = se && (ws_i != ws_last_q);

  // Idle clears the buffer every cycle, so nothing is accepted there.
  assign tx_ready_o = en_i && !buf_vld_q && (ctrl_q.state != StIdle);
  assign hs         = tx_valid_i && tx_ready_o;

  // Left-justify the N-bit sample so its MSB lands in shreg bit DATA_W-1.
  assign n_ext = 32'(ctrl_q.n);
  assign shamt = (n_ext < DATA_W) ? (DATA_W - n_ext) : '0;

  always_comb begin
    ctrl_d          = ctrl_q;
    ctrl_d.underrun = 1'b0;
    buf_word_d      = buf_word_q;
    shreg_d         = shreg_q;

    if (!en_i || (ctrl_q.state == StIdle)) begin
      ctrl_d.state   = en_i ? StSync : StIdle;
      ctrl_d.buf_vld = 1'b0;
      ctrl_d.cnt     = '0;
      ctrl_d.ws_last = ws_i;
      ctrl_d.sd      = 1'b0;
      ctrl_d.n       = chl_bits(chl_e'(chl_i));
      ctrl_d.pol     = pol_i;
      buf_word_d     = '0;
      shreg_d        = '0;
    end else begin
      if (se) begin
        ctrl_d.ws_last = ws_i;
      end

      if (wsc) begin
        ctrl_d.state    = StRun;
        // Last bit of the previous word goes out one SCK after the WS change.
        ctrl_d.sd       = (ctrl_q.cnt != '0) && shreg_q[DATA_W-1];
        shreg_d         = buf_vld_q ? (buf_word_q << shamt) : '0;
        ctrl_d.cnt      = ctrl_q.n;
        ctrl_d.buf_vld  = 1'b0;
        ctrl_d.underrun = !buf_vld_q;
      end else if (se && (ctrl_q.state == StRun)) begin
        if (ctrl_q.cnt != '0) begin
          ctrl_d.sd  = shreg_q[DATA_W-1];
          shreg_d    = shreg_q << 1;
          ctrl_d.cnt = ctrl_q.cnt - 6'd1;
        end else begin
          ctrl_d.sd = 1'b0;
        end
      end

      // A write in the same cycle as a load lands after it: held for the next channel.
      if (hs) begin
        ctrl_d.buf_vld = 1'b1;
        buf_word_d     = tx_data_i;
      end
    end
  end

  i2s_txser_reg #(
    .Width($bits(tx_ctrl_t))
  ) u_ctrl_reg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (ctrl_d),
    .q_o  (ctrl_q)
  );

  i2s_txser_reg #(
    .Width(2 * DATA_W)
  ) u_data_reg (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  ({buf_word_d, shreg_d}),
    .q_o  ({buf_word_q, shreg_q})
  );

  assign sd_o       = ctrl_q.sd;
  assign underrun_o = ctrl_q.underrun;
  assign busy_o     = (ctrl_q.state == StRun);

endmodule

// File: tb/tb_i2s_txser.sv
// Bench for i2s_txser: a bench-side SCK/WS generator, a queue-based stream
// model of the expected serial output, table vectors, corner sequences and
// randomized runs.
module tb_i2s_txser;

  localparam int unsigned DW = 32;
  localparam int HALF = 2;  // clk cycles per SCK half period

  logic          clk;
  logic          rst, en, pol, sck, sck_trg, ws, tx_valid;
  logic [1:0]    chl;
  logic [DW-1:0] tx_data;
  logic          tx_ready, sd, underrun, busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2s_txser #(
    .DATA_W(DW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .pol_i     (pol),
    .chl_i     (chl),
    .sck_i     (sck),
    .sck_trg_i (sck_trg),
    .ws_i      (ws),
    .tx_data_i (tx_data),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .sd_o      (sd),
    .underrun_o(underrun),
    .busy_o    (busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 waiting for WS edge, 2 transmitting.
  int          m_mode;
  logic        m_bv, m_wslast, m_pol, m_sd, m_und;
  logic [31:0] m_buf;
  int          m_n;
  bit          exp_q[$];  // bits still to be sent for the current channel

  int          ph, bitpos, slot_len;
  logic [31:0] src_q[$];
  bit          gate_wsc, rand_valid;
  bit          cap_on;
  logic [31:0] cap_val;
  logic [31:0] cap_q[$];
  int          und_cnt, ones_seen;

  typedef struct {
    logic [1:0]  chl;
    logic        pol;
    int          slot;
    logic [31:0] wl, wr, exp_l, exp_r;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic se, wsc, hs, was_run, pred;
    se      = sck_trg && (sck != m_pol);
    wsc     = 1'b0;
    hs      = 1'b0;
    was_run = (m_mode == 2);
    if (rst) begin
      m_mode = 0; m_bv = 0; m_buf = 0; m_wslast = 0; m_n = 0; m_pol = 0;
      m_sd = 0; m_und = 0; exp_q.delete();
    end else if (!en || m_mode == 0) begin
      m_mode = en ? 1 : 0; m_bv = 0; m_buf = 0; m_wslast = ws;
      m_n = 8 * (int'(chl) + 1); m_pol = pol; m_sd = 0; m_und = 0; exp_q.delete();
    end else begin
      hs    = tx_valid && !m_bv;
      wsc   = se && (ws != m_wslast);
      m_und = 0;
      if (wsc) begin
        m_sd = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        exp_q.delete();
        if (m_bv) begin
          for (int i = m_n - 1; i >= 0; i--) exp_q.push_back(m_buf[i]);
        end else begin
          m_und = 1;
        end
        m_bv = 0;
        m_mode = 2;
      end else if (se && m_mode == 2) begin
        m_sd = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
      end
      if (se) m_wslast = ws;
      if (hs) begin
        m_bv = 1;
        m_buf = tx_data;
      end
    end
    if (hs) src_q.delete(0);

    @(posedge clk);
    #1;
    chk("sd", sd, m_sd);
    chk("underrun", underrun, m_und);
    chk("busy", busy, m_mode == 2);
    chk("tx_ready", tx_ready, en && !m_bv && m_mode != 0);
    und_cnt   += int'(underrun);
    ones_seen += int'(sd);

    // Slot capture: bits after shift events 1..slot, last one at the next WS edge.
    if (m_mode == 0) begin
      cap_on = 0;
    end else if (wsc) begin
      if (cap_on) cap_q.push_back({cap_val[30:0], sd});
      cap_on  = 1;
      cap_val = '0;
    end else if (se && was_run && cap_on) begin
      cap_val = {cap_val[30:0], sd};
    end

    // Clock generator: WS flips together with the trigger of the slot's last shift event.
    if (sck_trg) sck = ~sck;
    ph      = (ph + 1) % HALF;
    sck_trg = (ph == HALF - 1);
    if (sck_trg && (sck != pol)) begin
      bitpos++;
      if (bitpos >= slot_len) begin
        bitpos = 0;
        ws = ~ws;
      end
    end

    pred     = sck_trg && (sck != m_pol) && (ws != m_wslast);
    tx_valid = (src_q.size() > 0) && (!gate_wsc || pred);
    if (rand_valid && $urandom_range(0, 3) == 0) tx_valid = 1'b0;
    tx_data = (src_q.size() > 0) ? src_q[0] : 32'($urandom);
  endtask

  task automatic configure(input logic [1:0] c, input logic p, input int slot);
    en = 0; gate_wsc = 0; rand_valid = 0;
    src_q.delete();
    step();
    chl = c; pol = p; sck = p; sck_trg = 0; ph = 0; ws = 1; bitpos = 0; slot_len = slot;
    tx_valid = 0;
    step();
    step();
    cap_q.delete();
    und_cnt = 0;
    ones_seen = 0;
  endtask

  task automatic wait_caps(input int k, input string name);
    int budget = 20000;
    while (cap_q.size() < k && budget > 0) begin
      step();
      budget--;
    end
    chk(name, 32'(cap_q.size() >= k), 32'd1);
  endtask

  task automatic wait_run(input string name);
    int budget = 5000;
    while (m_mode != 2 && budget > 0) begin
      step();
      budget--;
    end
    chk(name, busy, 1'b1);
  endtask

  function automatic logic [31:0] cap_at(input int i);
    return (cap_q.size() > i) ? cap_q[i] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    rst = 1; en = 0; pol = 0; chl = 2'd1; sck = 0; sck_trg = 0; ws = 1;
    tx_valid = 0; tx_data = '0; ph = 0; bitpos = 0; slot_len = 32;
    gate_wsc = 0; rand_valid = 0; cap_on = 0; cap_val = '0; und_cnt = 0; ones_seen = 0;
    m_mode = 0; m_bv = 0; m_wslast = 0; m_pol = 0; m_sd = 0; m_und = 0; m_buf = 0; m_n = 0;

    // Reset state.
    repeat (3) step();
    chk("reset_sd", sd, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ready", tx_ready, 1'b0);
    chk("reset_underrun", underrun, 1'b0);
    rst = 0;

    // Table vectors: expected slot contents, MSB-first, captured left-justified.
    vecs[0] = '{2'd1, 1'b0, 32, 32'h0000A5C3, 32'h00000F0F, 32'hA5C30000, 32'h0F0F0000};
    vecs[1] = '{2'd0, 1'b0, 32, 32'h00000081, 32'h0000007E, 32'h81000000, 32'h7E000000};
    vecs[2] = '{2'd2, 1'b1, 32, 32'h00123456, 32'h00ABCDEF, 32'h12345600, 32'hABCDEF00};
    vecs[3] = '{2'd3, 1'b0, 32, 32'hDEADBEEF, 32'h80000001, 32'hDEADBEEF, 32'h80000001};
    vecs[4] = '{2'd1, 1'b0, 16, 32'h0000A5C3, 32'h00000F0F, 32'h0000A5C3, 32'h00000F0F};
    vecs[5] = '{2'd0, 1'b1, 32, 32'hFFFFFF81, 32'h12345601, 32'h81000000, 32'h01000000};
    for (int v = 0; v < 6; v++) begin
      configure(vecs[v].chl, vecs[v].pol, vecs[v].slot);
      src_q.push_back(vecs[v].wl);
      src_q.push_back(vecs[v].wr);
      src_q.push_back(32'h0);
      en = 1;
      wait_caps(2, $sformatf("vec%0d_done", v));
      chk($sformatf("vec%0d_left", v), cap_at(0), vecs[v].exp_l);
      chk($sformatf("vec%0d_right", v), cap_at(1), vecs[v].exp_r);
      chk($sformatf("vec%0d_no_underrun", v), 32'(und_cnt), 32'd0);
    end

    // Enabled with an empty buffer: zero slot, single underrun pulse.
    configure(2'd1, 1'b0, 32);
    en = 1;
    wait_run("underrun_run");
    repeat (20) step();
    chk("underrun_once", 32'(und_cnt), 32'd1);
    src_q.push_back(32'h00001234);
    wait_caps(2, "underrun_done");
    chk("underrun_zero_slot", cap_at(0), 32'h0);
    chk("underrun_next_word", cap_at(1), 32'h12340000);

    // Write accepted in the same cycle as a channel start: held for the next channel.
    configure(2'd0, 1'b0, 32);
    src_q.push_back(32'h81);
    en = 1;
    wait_run("same_cycle_run");
    gate_wsc = 1;
    src_q.push_back(32'h3C);
    wait_caps(3, "same_cycle_done");
    chk("same_cycle_first", cap_at(0), 32'h81000000);
    chk("same_cycle_empty", cap_at(1), 32'h0);
    chk("same_cycle_held", cap_at(2), 32'h3C000000);
    gate_wsc = 0;

    // Enable dropped mid-word, then re-enabled.
    configure(2'd3, 1'b0, 32);
    src_q.push_back(32'hFFFF_FFFF);
    src_q.push_back(32'hFFFF_FFFF);
    en = 1;
    wait_run("en_drop_run");
    repeat (40) step();
    en = 0;
    step();
    chk("en_drop_sd", sd, 1'b0);
    chk("en_drop_busy", busy, 1'b0);
    chk("en_drop_ready", tx_ready, 1'b0);
    src_q.delete();
    src_q.push_back(32'hC0FF_EE01);
    en = 1;
    cap_q.delete();
    ones_seen = 0;
    wait_run("en_back_run");
    chk("en_back_quiet", 32'(ones_seen), 32'd0);
    wait_caps(1, "en_back_done");
    chk("en_back_word", cap_at(0), 32'hC0FF_EE01);

    // Reset pulse mid-frame.
    configure(2'd2, 1'b0, 32);
    src_q.push_back(32'h00FF_FFFF);
    src_q.push_back(32'h00FF_FFFF);
    en = 1;
    wait_run("rst_run");
    repeat (30) step();
    und_cnt = 0;
    rst = 1;
    step();
    chk("rst_sd", sd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", tx_ready, 1'b0);
    chk("rst_underrun", underrun, 1'b0);
    rst = 0;
    step();
    chk("rst_no_underrun", 32'(und_cnt), 32'd0);
    repeat (300) step();

    // Randomized runs against the model.
    for (int r = 0; r < 12; r++) begin
      configure(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom_range(8, 40));
      en = 1;
      rand_valid = 1;
      for (int c = 0; c < 1500; c++) begin
        if (src_q.size() < 2 && $urandom_range(0, 7) == 0) src_q.push_back($urandom);
        rst = ($urandom_range(0, 2999) == 0);
        if (!en) en = 1;
        else if ($urandom_range(0, 999) == 0) en = 0;
        step();
      end
      rst = 0;
      rand_valid = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_txser.md
I2S_TXSER -- requirements
Module: i2s_txser

Interface
REQ-001 Parameter DATA_W, default 32, meaning max sample width and width of tx_data_i.
REQ-002 clk_i  input  1  system clock (same MCLK domain as the I2S clock generator).
REQ-003 rst_i  input  1  reset, synchronous, active-high.
REQ-004 en_i  input  1  transmitter enable; low forces IDLE.
REQ-005 pol_i  input  1  SCK idle level, identical to the clock generator setting.
REQ-006 chl_i  input  2  channel length code: 0=8, 1=16, 2=24, 3=32 bits.
REQ-007 sck_i  input  1  SCK level from the clock generator.
REQ-008 sck_trg_i  input  1  one-cycle pulse; SCK toggles on the following clk_i edge.
REQ-009 ws_i  input  1  word select from the clock generator; 0=left, 1=right.
REQ-010 tx_data_i  input  DATA_W  sample, LSB-aligned; bits above N ignored.
REQ-011 tx_valid_i  input  1  sample valid.
REQ-012 tx_ready_o  output  1  sample accepted when tx_valid_i && tx_ready_o.
REQ-013 sd_o  output  1  serial data.
REQ-014 underrun_o  output  1  one-cycle pulse on underrun.
REQ-015 busy_o  output  1  high in RUN state.

Function
REQ-016 Shift event SE = sck_trg_i && (sck_i != pol_i), i.e. SCK about to return to idle; all sd_o changes occur only on SE cycles.
REQ-017 N = 8*(chl_i+1); chl_i and pol_i sampled only in IDLE; changes while enabled are undefined.
REQ-018 Holding buffer: one entry; tx_ready_o = en_i && !buf_vld_q; accepted word stored next cycle with buf_vld_q=1.
REQ-019 ws_last_q records ws_i at each SE; WSC (channel start) = SE && (ws_i != ws_last_q).
REQ-020 FSM states IDLE, SYNC, RUN; IDLE->SYNC when en_i=1; SYNC->RUN on first WSC; any state->IDLE when en_i=0 (next cycle).
REQ-021 IDLE: sd_o=0, buffer cleared, bit counter 0, ws_last_q<=ws_i each cycle.
REQ-022 SYNC: sd_o=0, buffer may fill, no loads, no underrun.
REQ-023 On WSC (SYNC or RUN): shift register <= buffer word left-justified to bit DATA_W-1, bit counter <= N, buffer consumed (buf_vld_q<=0); sd_o <= remaining bit of previous word if counter>0 else 0 (one-SCK I2S delay).
REQ-024 On WSC with buf_vld_q=0: shift register <= 0, counter <= N, underrun_o=1 for that cycle, no stall.
REQ-025 Write and WSC in same cycle: load sees pre-write buffer state; the written word is held for the next channel.
REQ-026 On non-WSC SE in RUN: if counter>0, sd_o <= shreg MSB, shreg shifts left 1, counter decrements; else sd_o <= 0 (slot padding).
REQ-027 First SE after WSC outputs MSB of new word; Nth outputs LSB; bits beyond N output 0.
REQ-028 Counter width 6 bits, never wraps below 0.

Reset
REQ-029 rst_i=1: state IDLE, sd_o=0, tx_ready_o=0 (registered view), underrun_o=0, busy_o=0, buffer, shreg, counter, ws_last_q all 0.
REQ-030 Reset mid-word abandons the word without underrun pulse; post-reset alignment restarts via SYNC.

Structure
REQ-031 Channel-length codes and the N lookup live in the shared i2s_define package alongside existing I2S_DAT_* codes; FSM state enum in the same package.
REQ-032 Flops use the codebase sync-reset register cell; no sub-module beyond it; the clock generator is instantiated only by the parent.

Verification
REQ-033 chl=16 bits, pol=0, write 0xA5C3 left, 0x0F0F right -> sd_o MSB-first 1010010111000011 starting one SCK after ws falls, then 0000111100001111 after ws rises; no underrun.
REQ-034 Enable with buffer empty at first WSC -> slot of zeros, underrun_o single pulse, busy_o=1.
REQ-035 chl=8 in 32-SCK slot, data 0x81 -> bits 10000001 then 24 zeros.
REQ-036 tx_valid_i held and WSC same cycle as acceptance -> previously buffered word transmitted, new word held for next channel, tx_ready_o low one cycle after.
REQ-037 Deassert en_i mid-word -> IDLE next cycle, sd_o=0, buffer cleared; reassert -> SYNC, no output until next ws edge.
REQ-038 rst_i pulse mid-frame -> all outputs 0 next cycle, no underrun pulse.
